// File: rtl/skullfet_bist_ctrl.sv
// BIST sequencer for one skullfet inverter and one skullfet NAND cell: sweeps all four
// input vectors for NUM_ROUNDS passes, checks the cell outputs, and reports pass/fail.
module skullfet_bist_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned NUM_ROUNDS    = 16,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             inv_a,
  output logic             nand_a,
  output logic             nand_b,
  input  logic             inv_y,
  input  logic             nand_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic             inv_fail,
  output logic             nand_fail
);

  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned RW = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSettle = 2'd1;
  localparam logic [1:0] StCheck  = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [RW-1:0]    round_q, round_d;
  logic             a_q, a_d, b_q, b_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             inv_fail_q, inv_fail_d, nand_fail_q, nand_fail_d;
  logic             inv_mis, nand_mis;
  logic [1:0]       v_next;

  // Case inequality so that X/Z from an unpowered cell counts as a mismatch.
  assign inv_mis  = (inv_y !== ~a_q);
  assign nand_mis = (nand_y !== ~(a_q & b_q));
  assign v_next   = {a_q, b_q} + 2'd1;

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    round_d     = round_q;
    a_d         = a_q;
    b_d         = b_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_d       = err_q;
    inv_fail_d  = inv_fail_q;
    nand_fail_d = nand_fail_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StSettle;
          settle_d    = '0;
          round_d     = '0;
          a_d         = 1'b0;
          b_d         = 1'b0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_d       = '0;
          inv_fail_d  = 1'b0;
          nand_fail_d = 1'b0;
        end
      end
      StSettle, StCheck: begin
        if (abort) begin
          state_d = StIdle;
          a_d     = 1'b0;
          b_d     = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (state_q == StSettle) begin
          if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
            state_d = StCheck;
          end else begin
            settle_d = settle_q + SW'(1);
          end
        end else begin
          // One error count per vector even if both cells disagree.
          if ((inv_mis || nand_mis) && (err_q != '1)) begin
            err_d = err_q + CNT_W'(1);
          end
          inv_fail_d  = inv_fail_q | inv_mis;
          nand_fail_d = nand_fail_q | nand_mis;
          if ({a_q, b_q} == 2'd3 && round_q == RW'(NUM_ROUNDS - 1)) begin
            state_d = StDone;
            a_d     = 1'b0;
            b_d     = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            state_d  = StSettle;
            settle_d = '0;
            a_d      = v_next[1];
            b_d      = v_next[0];
            if ({a_q, b_q} == 2'd3) begin
              round_d = round_q + RW'(1);
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      settle_q    <= '0;
      round_q     <= '0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      inv_fail_q  <= 1'b0;
      nand_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      round_q     <= round_d;
      a_q         <= a_d;
      b_q         <= b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      inv_fail_q  <= inv_fail_d;
      nand_fail_q <= nand_fail_d;
    end
  end

  assign inv_a     = a_q;
  assign nand_a    = a_q;
  assign nand_b    = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign inv_fail  = inv_fail_q;
  assign nand_fail = nand_fail_q;

endmodule

// File: tb/tb_skullfet_bist_ctrl.sv
// Directed bench for skullfet_bist_ctrl: a main instance (8-bit counter) and a 2-bit counter
// instance driven in parallel with a stuck-at-0 inverter to exercise saturation.
module tb_skullfet_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       inv_a, nand_a, nand_b, inv_y, nand_y;
  logic       busy, done, pass, inv_fail, nand_fail;
  logic [7:0] err_count;
  int         inv_mode = 0;
  int         nand_mode = 0;
  logic       x_val;

  logic       s_inv_a, s_nand_a, s_nand_b, s_nand_y;
  logic       s_busy, s_done, s_pass, s_inv_fail, s_nand_fail;
  logic [1:0] s_err;

  int checks = 0;
  int failures = 0;
  int ncyc;
  int exp_x;

  always #5 clk = ~clk;

  // Cell models: 0 ideal, 1 unknown output, 2 always wrong / tied high
  always_comb begin
    inv_y = ~inv_a;
    if (inv_mode == 1) inv_y = x_val;
    else if (inv_mode == 2) inv_y = inv_a;
  end
  always_comb begin
    nand_y = ~(nand_a & nand_b);
    if (nand_mode == 1) nand_y = 1'b1;
  end
  assign s_nand_y = ~(s_nand_a & s_nand_b);

  skullfet_bist_ctrl #(.SETTLE_CYCLES(4), .NUM_ROUNDS(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .inv_a(inv_a), .nand_a(nand_a), .nand_b(nand_b), .inv_y(inv_y), .nand_y(nand_y),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .inv_fail(inv_fail), .nand_fail(nand_fail)
  );

  skullfet_bist_ctrl #(.SETTLE_CYCLES(4), .NUM_ROUNDS(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .inv_a(s_inv_a), .nand_a(s_nand_a), .nand_b(s_nand_b), .inv_y(1'b0), .nand_y(s_nand_y),
    .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err),
    .inv_fail(s_inv_fail), .nand_fail(s_nand_fail)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse start for one cycle, then count busy cycles (bounded) until the run ends.
  task automatic run_to_done(output int cyc);
    cyc = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (busy && cyc < 1000) begin
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    x_val = 1'bx;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_stim", {inv_a, nand_a, nand_b}, 0);
    check("rst_flags", {inv_fail, nand_fail}, 0);
    @(negedge clk) rst_n = 1'b1;

    // 1: ideal cells
    run_to_done(ncyc);
    check("t1_busy_cycles", ncyc, 40);
    check("t1_done", done, 1);
    check("t1_pass", pass, 1);
    check("t1_err", err_count, 0);
    check("t1_stim", {inv_a, nand_a, nand_b}, 0);
    // 4: 2-bit counter with inverter stuck at 0 ran alongside
    check("t4_sat_err", s_err, 3);
    check("t4_sat_pass", s_pass, 0);
    check("t4_sat_flags", {s_inv_fail, s_nand_fail}, 2'b10);

    // 2: NAND output tied high
    nand_mode = 1;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("t2_start_clears", {done, pass, busy}, 3'b001);
    ncyc = 1;
    while (busy && ncyc < 1000) begin
      ncyc++;
      @(posedge clk);
      #1;
    end
    check("t2_err", err_count, 2);
    check("t2_flags", {inv_fail, nand_fail}, 2'b01);
    check("t2_pass", {done, pass}, 2'b10);
    nand_mode = 0;

    // 3: inverter output unknown; a 2-state simulator collapses X to a constant
    inv_mode = 1;
    exp_x = $isunknown(x_val) ? 8 : 4;
    run_to_done(ncyc);
    check("t3_err", err_count, exp_x);
    check("t3_flags", {inv_fail, nand_fail}, 2'b10);
    // 3b: inverter wrong on every vector
    inv_mode = 2;
    run_to_done(ncyc);
    check("t3b_err", err_count, 8);
    check("t3b_pass", pass, 0);
    inv_mode = 0;

    // 5: start ignored while busy, abort (with start) at cycle 10
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    check("t5_stim_c5", {inv_a, nand_a, nand_b}, 3'b001);
    repeat (5) @(posedge clk);
    #1;
    check("t5_stim_c10", {inv_a, nand_a, nand_b}, 3'b110);
    check("t5_busy_c10", busy, 1);
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    start = 1'b0;
    check("t5_abort_state", {busy, done, pass}, 0);
    check("t5_abort_stim", {inv_a, nand_a, nand_b}, 0);
    check("t5_sat_partial", s_err, 2);
    repeat (2) @(posedge clk);
    #1;
    check("t5_stays_idle", busy, 0);

    // 6: asynchronous reset mid-SETTLE
    nand_mode = 1;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (26) @(posedge clk);
    #1;
    check("t6_pre_err", err_count, 1);
    check("t6_pre_stim", {inv_a, nand_a, nand_b}, 3'b001);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_async", {busy, inv_a, nand_a, nand_b}, 0);
    check("t6_rst_err", err_count, 0);
    @(negedge clk) rst_n = 1'b1;
    nand_mode = 0;
    run_to_done(ncyc);
    check("t6_clean_cycles", ncyc, 40);
    check("t6_clean_pass", {done, pass, err_count}, {2'b11, 8'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
